// File: rtl/multi_object_slot_manager.sv
// Object slot manager: OBJECT_AMOUNT slots with a valid/ready spawn port, per-tick movement,
// centi-second lifetime, combinational pixel render and a registered player-hit mask.
module multi_object_slot_manager #(
  parameter int OBJECT_AMOUNT = 8,
  parameter int SPEED_W       = 5,
  parameter int LIFE_W        = 8,
  parameter int IDX_W         = (OBJECT_AMOUNT > 1) ? $clog2(OBJECT_AMOUNT) : 1
) (
  input  logic                     clk_calculation,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     centi_tick,
  input  logic                     spawn_valid,
  output logic                     spawn_ready,
  input  logic [2:0]               spawn_dir,
  input  logic [9:0]               spawn_x,
  input  logic [9:0]               spawn_y,
  input  logic [9:0]               spawn_w,
  input  logic [9:0]               spawn_h,
  input  logic [SPEED_W-1:0]       spawn_speed,
  input  logic [LIFE_W-1:0]        spawn_life,
  output logic [IDX_W-1:0]         spawn_slot,
  input  logic [9:0]               display_x1,
  input  logic [9:0]               display_y1,
  input  logic [9:0]               display_x2,
  input  logic [9:0]               display_y2,
  input  logic [9:0]               player_x,
  input  logic [9:0]               player_y,
  input  logic [9:0]               player_w,
  input  logic [9:0]               player_h,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  output logic                     object_signal,
  output logic [OBJECT_AMOUNT-1:0] active_mask,
  output logic [OBJECT_AMOUNT-1:0] hit_mask,
  output logic                     is_trigger_player,
  output logic [IDX_W-1:0]         hit_index,
  output logic [15:0]              drop_count
);

  localparam int N = OBJECT_AMOUNT;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef struct packed {
    logic [9:0]         x;
    logic [9:0]         y;
    logic [9:0]         w;
    logic [9:0]         h;
    logic [2:0]         dir;
    logic [SPEED_W-1:0] speed;
    logic [LIFE_W-1:0]  life;
  } slot_t;

  slot_t            slot_q [N];
  slot_t            slot_d [N];
  logic [N-1:0]     active_q, active_d;
  logic [N-1:0]     hit_q, hit_d;
  logic             ready_q, ready_d;
  logic             trig_q, trig_d;
  logic [IDX_W-1:0] spawn_slot_q, spawn_slot_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic [15:0]      drop_q, drop_d;
  logic [IDX_W-1:0] free_idx;
  logic             accept;

  // ready_q always mirrors "some slot is free", so a free index exists whenever accept is high.
  assign accept = spawn_valid && ready_q;

  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    active_d = active_q;
    slot_d   = slot_q;
    for (int i = 0; i < N; i++) begin : g_slot
      logic [10:0] mx, my, spd;
      logic        lost, expired;
      mx      = {1'b0, slot_q[i].x};
      my      = {1'b0, slot_q[i].y};
      spd     = 11'(slot_q[i].speed);
      expired = 1'b0;
      if (tick) begin
        case (slot_q[i].dir)
          DIR_UP:    my = my - spd;
          DIR_DOWN:  my = my + spd;
          DIR_LEFT:  mx = mx - spd;
          DIR_RIGHT: mx = mx + spd;
          default:   ;
        endcase
      end
      // Bit 10 flags both an underflow below 0 and a result above 1023.
      lost = mx[10] || my[10]
          || (mx + {1'b0, slot_q[i].w} <= {1'b0, display_x1}) || (mx >= {1'b0, display_x2})
          || (my + {1'b0, slot_q[i].h} <= {1'b0, display_y1}) || (my >= {1'b0, display_y2});
      if (centi_tick && slot_q[i].life != '0) begin
        expired = (slot_q[i].life == LIFE_W'(1));
        if (active_q[i]) slot_d[i].life = slot_q[i].life - LIFE_W'(1);
      end
      if (active_q[i]) begin
        slot_d[i].x = mx[9:0];
        slot_d[i].y = my[9:0];
        if (lost || expired) active_d[i] = 1'b0;
      end
      if (accept && free_idx == IDX_W'(i)) begin
        slot_d[i]   = '{x: spawn_x, y: spawn_y, w: spawn_w, h: spawn_h, dir: spawn_dir,
                        speed: spawn_speed, life: spawn_life};
        active_d[i] = 1'b1;
      end
    end
  end

  assign ready_d      = ~&active_d;
  assign spawn_slot_d = accept ? free_idx : spawn_slot_q;
  assign drop_d       = (spawn_valid && !ready_q && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

  always_comb begin
    hit_d       = '0;
    hit_index_d = '0;
    for (int i = 0; i < N; i++) begin
      hit_d[i] = active_q[i] && (slot_q[i].w != '0) && (slot_q[i].h != '0)
              && ({1'b0, player_x} < {1'b0, slot_q[i].x} + {1'b0, slot_q[i].w})
              && ({1'b0, player_x} + {1'b0, player_w} > {1'b0, slot_q[i].x})
              && ({1'b0, player_y} < {1'b0, slot_q[i].y} + {1'b0, slot_q[i].h})
              && ({1'b0, player_y} + {1'b0, player_h} > {1'b0, slot_q[i].y});
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_d[i]) hit_index_d = IDX_W'(i);
    end
  end

  assign trig_d = |hit_d;

  always_comb begin
    object_signal = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (active_q[i] && x >= slot_q[i].x && {1'b0, x} < {1'b0, slot_q[i].x} + {1'b0, slot_q[i].w}
          && y >= slot_q[i].y && {1'b0, y} < {1'b0, slot_q[i].y} + {1'b0, slot_q[i].h})
        object_signal = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_calculation) begin
    if (reset) begin
      active_q     <= '0;
      hit_q        <= '0;
      ready_q      <= 1'b1;
      trig_q       <= 1'b0;
      spawn_slot_q <= '0;
      hit_index_q  <= '0;
      drop_q       <= '0;
      // NOTE: slot storage is cleared too, so a reset leaves no stale object data behind.
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
    end else begin
      active_q     <= active_d;
      hit_q        <= hit_d;
      ready_q      <= ready_d;
      trig_q       <= trig_d;
      spawn_slot_q <= spawn_slot_d;
      hit_index_q  <= hit_index_d;
      drop_q       <= drop_d;
      slot_q       <= slot_d;
    end
  end

  assign spawn_ready       = ready_q;
  assign spawn_slot        = spawn_slot_q;
  assign active_mask       = active_q;
  assign hit_mask          = hit_q;
  assign is_trigger_player = trig_q;
  assign hit_index         = hit_index_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_multi_object_slot_manager.sv
// Self-checking bench for multi_object_slot_manager: spawn scoreboard, render/hit vector tables
// and hand-written sequences for movement, lifetime, full-slot drops and reset.
module tb_multi_object_slot_manager;

  localparam int N = 8;
  localparam logic [2:0] D_STOP = 3'd0, D_LEFT = 3'd3, D_RIGHT = 3'd4;

  logic clk_calculation = 1'b0;
  logic reset, tick, centi_tick, spawn_valid, spawn_ready;
  logic [2:0] spawn_dir, spawn_slot, hit_index;
  logic [9:0] spawn_x, spawn_y, spawn_w, spawn_h;
  logic [4:0] spawn_speed;
  logic [7:0] spawn_life;
  logic [9:0] display_x1, display_y1, display_x2, display_y2;
  logic [9:0] player_x, player_y, player_w, player_h, x, y;
  logic object_signal, is_trigger_player;
  logic [N-1:0] active_mask, hit_mask;
  logic [15:0] drop_count;

  always #5 clk_calculation = ~clk_calculation;

  multi_object_slot_manager #(.OBJECT_AMOUNT(N)) dut (
    .clk_calculation(clk_calculation), .reset(reset), .tick(tick), .centi_tick(centi_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_dir(spawn_dir),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
    .spawn_speed(spawn_speed), .spawn_life(spawn_life), .spawn_slot(spawn_slot),
    .display_x1(display_x1), .display_y1(display_y1), .display_x2(display_x2), .display_y2(display_y2),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .x(x), .y(y), .object_signal(object_signal), .active_mask(active_mask), .hit_mask(hit_mask),
    .is_trigger_player(is_trigger_player), .hit_index(hit_index), .drop_count(drop_count)
  );

  typedef struct { logic [9:0] px, py; logic exp_sig; } pix_vec_t;
  typedef struct { logic [9:0] px, py, pw, ph; logic [7:0] exp_mask; logic [2:0] exp_idx; } hit_vec_t;

  pix_vec_t     pix_tab [7];
  hit_vec_t     hit_tab [5];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [N-1:0] exp_active;
  logic [2:0]   slot_sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_calculation);
    #1;
  endtask

  function automatic int lowest_free(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (!m[i]) return i;
    return -1;
  endfunction

  task automatic set_obj(input logic [9:0] ox, input logic [9:0] oy, input logic [9:0] ow,
                         input logic [9:0] oh, input logic [2:0] dir, input logic [4:0] spd,
                         input logic [7:0] life);
    spawn_x = ox; spawn_y = oy; spawn_w = ow; spawn_h = oh;
    spawn_dir = dir; spawn_speed = spd; spawn_life = life;
  endtask

  // Drives one cycle of spawn_valid; the model predicts the slot and the scoreboard checks it.
  task automatic spawn_cycle();
    int f;
    f = lowest_free(exp_active);
    spawn_valid = 1'b1;
    if (f >= 0) begin
      slot_sb.push_back(3'(f));
      exp_active[f] = 1'b1;
    end
    step();
    if (f >= 0) check("spawn_slot", 32'(spawn_slot), 32'(slot_sb.pop_front()));
  endtask

  task automatic do_reset();
    reset = 1'b1; spawn_valid = 1'b0; tick = 1'b0; centi_tick = 1'b0;
    step();
    reset = 1'b0;
    exp_active = '0;
    slot_sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pix_tab[0] = '{10'd113, 10'd113, 1'b1};
    pix_tab[1] = '{10'd117, 10'd117, 1'b1};
    pix_tab[2] = '{10'd118, 10'd110, 1'b0};
    pix_tab[3] = '{10'd110, 10'd118, 1'b0};
    pix_tab[4] = '{10'd105, 10'd105, 1'b0};
    pix_tab[5] = '{10'd123, 10'd107, 1'b1};
    pix_tab[6] = '{10'd124, 10'd107, 1'b0};
    hit_tab[0] = '{10'd100, 10'd100, 10'd16,  10'd16,  8'h04, 3'd2};
    hit_tab[1] = '{10'd94,  10'd110, 10'd16,  10'd16,  8'h00, 3'd0};
    hit_tab[2] = '{10'd118, 10'd110, 10'd16,  10'd16,  8'h00, 3'd0};
    hit_tab[3] = '{10'd295, 10'd295, 10'd8,   10'd8,   8'h01, 3'd0};
    hit_tab[4] = '{10'd100, 10'd100, 10'd310, 10'd310, 8'h17, 3'd0};

    display_x1 = 10'd0; display_y1 = 10'd0; display_x2 = 10'd640; display_y2 = 10'd480;
    player_x = 10'd1000; player_y = 10'd1000; player_w = 10'd4; player_h = 10'd4;
    x = '0; y = '0;
    set_obj(10'd200, 10'd200, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0);

    // Reset values
    do_reset();
    check("reset_active", 32'(active_mask), 0);
    check("reset_hit", 32'(hit_mask), 0);
    check("reset_trig", 32'(is_trigger_player), 0);
    check("reset_hit_index", 32'(hit_index), 0);
    check("reset_spawn_slot", 32'(spawn_slot), 0);
    check("reset_drop", 32'(drop_count), 0);
    check("reset_ready", 32'(spawn_ready), 1);

    // Three back-to-back spawns, valid held
    for (int k = 0; k < 3; k++) begin
      spawn_cycle();
      check("ready_partial", 32'(spawn_ready), 1);
    end
    check("active_three", 32'(active_mask), 32'h07);

    // Fill remaining slots, then hold valid four more cycles
    for (int k = 0; k < 5; k++) spawn_cycle();
    check("ready_full", 32'(spawn_ready), 0);
    for (int k = 0; k < 4; k++) step();
    spawn_valid = 1'b0;
    check("drop_four", 32'(drop_count), 4);
    check("active_full", 32'(active_mask), 32'hFF);
    check("slot_kept", 32'(spawn_slot), 7);

    // Left move below 0 despawns; freed slot 0 is reused on the next spawn
    do_reset();
    set_obj(10'd5, 10'd200, 10'd8, 10'd8, D_LEFT, 5'd10, 8'd0);
    spawn_cycle();
    set_obj(10'd200, 10'd200, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0);
    spawn_cycle();
    spawn_valid = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    exp_active[0] = 1'b0;
    check("left_underflow", 32'(active_mask), 32'h02);
    check("ready_after_free", 32'(spawn_ready), 1);
    spawn_cycle();
    spawn_valid = 1'b0;
    check("reuse_active", 32'(active_mask), 32'h03);

    // Right movement inside the window, then exit at x2, then overflow past 1023
    do_reset();
    set_obj(10'd620, 10'd200, 10'd8, 10'd8, D_RIGHT, 5'd10, 8'd0);
    spawn_cycle();
    spawn_valid = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    check("move_in_window", 32'(active_mask), 32'h01);
    x = 10'd630; y = 10'd200; #1;
    check("moved_render_in", 32'(object_signal), 1);
    x = 10'd629; #1;
    check("moved_render_out", 32'(object_signal), 0);
    tick = 1'b1; step(); tick = 1'b0;
    check("window_exit", 32'(active_mask), 0);
    display_x2 = 10'd1023;
    exp_active = '0;
    set_obj(10'd1015, 10'd200, 10'd2, 10'd8, D_RIGHT, 5'd9, 8'd0);
    spawn_cycle();
    spawn_valid = 1'b0;
    check("edge_active", 32'(active_mask), 32'h01);
    tick = 1'b1; step(); tick = 1'b0;
    check("right_overflow", 32'(active_mask), 0);
    display_x2 = 10'd640;

    // Lifetime countdown and the never-expiring life=0
    do_reset();
    set_obj(10'd200, 10'd200, 10'd8, 10'd8, D_STOP, 5'd0, 8'd3);
    spawn_cycle();
    spawn_valid = 1'b0;
    centi_tick = 1'b1;
    step(); check("life_2", 32'(active_mask), 32'h01);
    step(); check("life_1", 32'(active_mask), 32'h01);
    step(); check("life_expire", 32'(active_mask), 0);
    centi_tick = 1'b0;
    exp_active = '0;
    set_obj(10'd200, 10'd200, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0);
    spawn_cycle();
    spawn_valid = 1'b0;
    centi_tick = 1'b1;
    for (int k = 0; k < 300; k++) step();
    centi_tick = 1'b0;
    check("life_zero_kept", 32'(active_mask), 32'h01);

    // Collision and render tables: slots 0,1 far away, 2 hits, 3 zero width, 4 edge-touching
    do_reset();
    set_obj(10'd300, 10'd300, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0); spawn_cycle();
    set_obj(10'd400, 10'd300, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0); spawn_cycle();
    set_obj(10'd110, 10'd110, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0); spawn_cycle();
    set_obj(10'd105, 10'd105, 10'd0, 10'd8, D_STOP, 5'd0, 8'd0); spawn_cycle();
    set_obj(10'd116, 10'd100, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0); spawn_cycle();
    spawn_valid = 1'b0;
    check("collide_active", 32'(active_mask), 32'h1F);
    for (int k = 0; k < 7; k++) begin
      x = pix_tab[k].px; y = pix_tab[k].py; #1;
      check($sformatf("render_%0d", k), 32'(object_signal), 32'(pix_tab[k].exp_sig));
    end
    step();
    check("hit_idle", 32'(hit_mask), 0);
    for (int k = 0; k < 5; k++) begin
      player_x = hit_tab[k].px; player_y = hit_tab[k].py;
      player_w = hit_tab[k].pw; player_h = hit_tab[k].ph;
      if (k == 0) begin
        #1;
        check("hit_latency", 32'(hit_mask), 0);
      end
      step();
      check($sformatf("hit_mask_%0d", k), 32'(hit_mask), 32'(hit_tab[k].exp_mask));
      check($sformatf("hit_index_%0d", k), 32'(hit_index), 32'(hit_tab[k].exp_idx));
      check($sformatf("hit_trig_%0d", k), 32'(is_trigger_player), 32'(hit_tab[k].exp_mask != 0));
    end
    player_x = 10'd1000; player_y = 10'd1000; player_w = 10'd4; player_h = 10'd4;

    // Reset during an accepted spawn plus tick, with a nonzero drop count
    do_reset();
    set_obj(10'd200, 10'd200, 10'd8, 10'd8, D_STOP, 5'd0, 8'd0);
    for (int k = 0; k < 7; k++) spawn_cycle();
    set_obj(10'd5, 10'd200, 10'd8, 10'd8, D_LEFT, 5'd10, 8'd0);
    spawn_cycle();
    step(); step();
    check("drop_two", 32'(drop_count), 2);
    tick = 1'b1; step();
    check("drop_three", 32'(drop_count), 3);
    check("ready_reopened", 32'(spawn_ready), 1);
    check("slot7_gone", 32'(active_mask), 32'h7F);
    reset = 1'b1; step();
    check("mid_reset_active", 32'(active_mask), 0);
    check("mid_reset_drop", 32'(drop_count), 0);
    check("mid_reset_ready", 32'(spawn_ready), 1);
    check("mid_reset_slot", 32'(spawn_slot), 0);
    check("mid_reset_hit", 32'(hit_mask), 0);
    check("mid_reset_trig", 32'(is_trigger_player), 0);
    reset = 1'b0; tick = 1'b0; spawn_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
